// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the P7 fetch PC sequencer.
package pc_seq_pkg;

    // Sequencer states: FETCH issues the request, VALID holds the fetched word.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO_DEF   = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI_DEF   = 32'h0000_6FFC;

    // sll $0,$0,0 -- the canonical nop, substituted for a faulting fetch.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pc_range_chk.sv
// Combinational fetch-address legality check: word alignment plus text range.
// Only built when PC_RANGE_CHECK_EN is defined.
`ifdef PC_RANGE_CHECK_EN
module pc_range_chk #(
    parameter logic [31:0] TEXT_LO = pc_seq_pkg::TEXT_LO_DEF,
    parameter logic [31:0] TEXT_HI = pc_seq_pkg::TEXT_HI_DEF
) (
    input  logic [31:0] addr,
    output logic        legal
);

    // Legal when word aligned and inside [TEXT_LO, TEXT_HI].
    always_comb begin
        legal = (addr[1:0] == 2'b00) && (addr >= TEXT_LO) && (addr <= TEXT_HI);
    end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the P7 pipeline: sequences instruction fetch against a
// ready-handshaked memory and applies exception / eret redirects ahead of
// stalls. Optional feature macro: PC_RANGE_CHECK_EN (fetch address check,
// raising adel and substituting a nop instead of issuing the request).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter logic [31:0] TEXT_LO   = TEXT_LO_DEF,
    parameter logic [31:0] TEXT_HI   = TEXT_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] next_pc,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_ready,
    input  logic [31:0] if_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        adel
);

    state_t      state;
    state_t      state_n;
    logic [31:0] pc_n;
    logic [31:0] instr_n;
    logic        adel_q;
    logic        adel_n;
    logic        fetch_legal;

`ifdef PC_RANGE_CHECK_EN
    pc_range_chk #(
        .TEXT_LO (TEXT_LO),
        .TEXT_HI (TEXT_HI)
    ) u_range_chk (
        .addr  (pc),
        .legal (fetch_legal)
    );
`else
    // Without the check every address is fetched; the text bounds are
    // folded into a sink so the parameter set stays identical in both builds.
    logic unused_text_bounds;
    assign unused_text_bounds = ^{TEXT_LO, TEXT_HI};
    assign fetch_legal        = 1'b1;
`endif

    // Next-state, next-PC and held-slot update; redirects outrank everything.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        adel_n  = adel_q;

        if (exc_req) begin
            pc_n    = EXC_ENTRY;
            state_n = ST_FETCH;
            adel_n  = 1'b0;
        end else if (eret) begin
            pc_n    = epc;
            state_n = ST_FETCH;
            adel_n  = 1'b0;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (!fetch_legal) begin
                        instr_n = NOP_INSTR;
                        adel_n  = 1'b1;
                        state_n = ST_VALID;
                    end else if (if_ready) begin
                        instr_n = if_rdata;
                        adel_n  = 1'b0;
                        state_n = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        pc_n    = next_pc;
                        state_n = ST_FETCH;
                    end
                end
                default: state_n = ST_FETCH;
            endcase
        end
    end

    // State and held-slot registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state  <= ST_FETCH;
            pc     <= PC_RESET;
            instr  <= NOP_INSTR;
            adel_q <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            instr  <= instr_n;
            adel_q <= adel_n;
        end
    end

    // Request is suppressed while in reset so nothing completes before release.
    always_comb begin
        if_req      = !reset && (state == ST_FETCH) && fetch_legal;
        if_addr     = pc;
        instr_valid = (state == ST_VALID);
        adel        = adel_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer. Expected values follow the
// build: PC_RANGE_CHECK_EN changes the results of the misaligned and
// out-of-range fetch rows.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] next_pc;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        adel;

    int checks = 0;
    int errors = 0;

`ifdef PC_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .next_pc     (next_pc),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ready    (if_ready),
        .if_rdata    (if_rdata),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .adel        (adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: each word is its address with a recognisable tag in the top half.
    assign if_rdata = if_addr ^ 32'hDEAD_0000;

    typedef struct {
        logic        stall;
        logic        exc;
        logic        eret;
        logic        rdy;
        logic [31:0] epc;
        logic [31:0] np;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_vld;
        logic [31:0] e_instr;
        logic        e_adel;
    } vec_t;

    function automatic vec_t mk(logic s, logic x, logic e, logic r,
                                logic [31:0] ep, logic [31:0] np,
                                logic [31:0] e_pc, logic e_req, logic e_vld,
                                logic [31:0] e_instr, logic e_adel);
        vec_t v;
        v.stall = s;  v.exc = x;  v.eret = e;  v.rdy = r;
        v.epc = ep;   v.np = np;
        v.e_pc = e_pc; v.e_req = e_req; v.e_vld = e_vld;
        v.e_instr = e_instr; v.e_adel = e_adel;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_req,
                             input logic e_vld, input logic [31:0] e_instr, input logic e_adel);
        check({tag, " pc"},          pc,                  e_pc);
        check({tag, " if_addr"},     if_addr,             e_pc);
        check({tag, " if_req"},      {31'b0, if_req},      {31'b0, e_req});
        check({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, e_vld});
        check({tag, " instr"},       instr,               e_instr);
        check({tag, " adel"},        {31'b0, adel},        {31'b0, e_adel});
    endtask

    vec_t vecs[25];

    initial begin
        // Columns: stall exc eret rdy epc next_pc | pc req vld instr adel (after the edge)
        vecs[0]  = mk(0,0,0,1, 32'h0, 32'h0,         32'h3000, 0,1, 32'hDEAD3000, 0);
        vecs[1]  = mk(0,0,0,1, 32'h0, 32'h3004,      32'h3004, 1,0, 32'hDEAD3000, 0);
        vecs[2]  = mk(0,0,0,1, 32'h0, 32'h0,         32'h3004, 0,1, 32'hDEAD3004, 0);
        vecs[3]  = mk(0,0,0,0, 32'h0, 32'h3008,      32'h3008, 1,0, 32'hDEAD3004, 0);
        vecs[4]  = mk(0,0,0,0, 32'h0, 32'h0,         32'h3008, 1,0, 32'hDEAD3004, 0);
        vecs[5]  = mk(0,0,0,1, 32'h0, 32'h0,         32'h3008, 0,1, 32'hDEAD3008, 0);
        vecs[6]  = mk(1,0,0,0, 32'h0, 32'h300C,      32'h3008, 0,1, 32'hDEAD3008, 0);
        vecs[7]  = mk(1,0,0,1, 32'h0, 32'h300C,      32'h3008, 0,1, 32'hDEAD3008, 0);
        vecs[8]  = mk(1,0,0,0, 32'h0, 32'h300C,      32'h3008, 0,1, 32'hDEAD3008, 0);
        vecs[9]  = mk(0,0,0,0, 32'h0, 32'h300C,      32'h300C, 1,0, 32'hDEAD3008, 0);
        vecs[10] = mk(1,0,0,0, 32'h0, 32'h0,         32'h300C, 1,0, 32'hDEAD3008, 0);
        vecs[11] = mk(1,0,0,1, 32'h0, 32'h0,         32'h300C, 0,1, 32'hDEAD300C, 0);
        vecs[12] = mk(1,1,0,0, 32'h0, 32'h3010,      32'h4180, 1,0, 32'hDEAD300C, 0);
        vecs[13] = mk(0,0,0,1, 32'h0, 32'h0,         32'h4180, 0,1, 32'hDEAD4180, 0);
        vecs[14] = mk(0,1,1,0, 32'h3010, 32'h4184,   32'h4180, 1,0, 32'hDEAD4180, 0);
        vecs[15] = mk(0,0,1,1, 32'h3020, 32'h0,      32'h3020, 1,0, 32'hDEAD4180, 0);
        vecs[16] = mk(0,0,0,1, 32'h0, 32'h0,         32'h3020, 0,1, 32'hDEAD3020, 0);
        vecs[17] = mk(1,0,1,0, 32'h6FFC, 32'h3024,   32'h6FFC, 1,0, 32'hDEAD3020, 0);
        vecs[18] = mk(0,0,0,1, 32'h0, 32'h0,         32'h6FFC, 0,1, 32'hDEAD6FFC, 0);
        vecs[19] = mk(0,0,1,0, 32'h3002, 32'h7000,   32'h3002, !CHK,0, 32'hDEAD6FFC, 0);
        vecs[20] = mk(0,0,0,1, 32'h0, 32'h0,         32'h3002, 0,1, CHK ? 32'h0 : 32'hDEAD3002, CHK);
        vecs[21] = mk(0,0,1,0, 32'h7000, 32'h3006,   32'h7000, !CHK,0, CHK ? 32'h0 : 32'hDEAD3002, 0);
        vecs[22] = mk(0,0,0,1, 32'h0, 32'h0,         32'h7000, 0,1, CHK ? 32'h0 : 32'hDEAD7000, CHK);
        vecs[23] = mk(0,1,0,1, 32'h0, 32'h7004,      32'h4180, 1,0, CHK ? 32'h0 : 32'hDEAD7000, 0);
        vecs[24] = mk(0,0,0,1, 32'h0, 32'h0,         32'h4180, 0,1, 32'hDEAD4180, 0);

        reset    = 1'b1;
        stall    = 1'b0;
        next_pc  = 32'h0;
        exc_req  = 1'b0;
        eret     = 1'b0;
        epc      = 32'h0;
        if_ready = 1'b1;

        // Reset state, held across several edges with memory ready.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0);

        // First cycle after release must request the reset PC.
        reset = 1'b0;
        #1;
        check("release if_req", {31'b0, if_req}, 32'd1);
        check("release if_addr", if_addr, 32'h3000);

        for (int i = 0; i < 25; i++) begin
            stall    = vecs[i].stall;
            exc_req  = vecs[i].exc;
            eret     = vecs[i].eret;
            if_ready = vecs[i].rdy;
            epc      = vecs[i].epc;
            next_pc  = vecs[i].np;
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_req,
                      vecs[i].e_vld, vecs[i].e_instr, vecs[i].e_adel);
        end

        // Reset asserted mid-fetch aborts at once and blocks completion.
        stall = 1'b0; exc_req = 1'b0; eret = 1'b1; epc = 32'h3010; if_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre-reset pc", pc, 32'h3010);
        eret = 1'b0; if_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async reset pc", pc, 32'h3000);
        check("async reset if_req", {31'b0, if_req}, 32'd0);
        @(posedge clk);
        #1;
        check("reset hold valid", {31'b0, instr_valid}, 32'd0);
        check("reset hold instr", instr, 32'h0);
        reset = 1'b0;
        #1;
        check("re-release if_req", {31'b0, if_req}, 32'd1);
        @(posedge clk);
        #1;
        check("re-release valid", {31'b0, instr_valid}, 32'd1);
        check("re-release instr", instr, 32'hDEAD3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the architectural fetch PC of the P7 pipeline and sequences instruction fetch against a ready-handshaked instruction memory. It consumes the combinational next-PC produced by the PC-calculation logic and applies stalls, exception entry and `eret` redirects with fixed priority. It presents a held instruction/valid pair to the IF/ID register. It sits between the hazard unit/CP0 and instruction memory.

## Interface
Parameters
- `PC_RESET`, 32'h0000_3000, PC loaded on reset.
- `EXC_ENTRY`, 32'h0000_4180, exception/interrupt handler address.
- `TEXT_LO`, 32'h0000_3000, lowest legal fetch address.
- `TEXT_HI`, 32'h0000_6FFC, highest legal fetch address.

Ports
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `stall` in 1: hazard unit hold; the instruction is not consumed.
- `next_pc` in 32: sequential, branch or jump target from PC calculation.
- `exc_req` in 1: CP0 exception or interrupt taken this cycle.
- `eret` in 1: `eret` committing this cycle.
- `epc` in 32: CP0 EPC.
- `if_req` out 1: fetch request.
- `if_addr` out 32: fetch address, equal to `pc`.
- `if_ready` in 1: memory returns `if_rdata` this cycle.
- `if_rdata` in 32: fetched word.
- `pc` out 32: PC of the current or held instruction.
- `instr` out 32: held instruction.
- `instr_valid` out 1: `instr` is valid for IF/ID.
- `adel` out 1: fetch address error for the held slot.

## Operation
- States: FETCH and VALID. The reset state is FETCH.
- FETCH
  - `if_req`=1 and `if_addr`=`pc`.
  - On `if_ready`: latch `if_rdata` into `instr`, set `instr_valid`=1, go to VALID.
  - Otherwise remain in FETCH.
- VALID
  - `if_req`=0 and `instr_valid`=1.
  - `!stall`: `pc`<=`next_pc`, `instr_valid`<=0, go to FETCH.
  - `stall`: hold all registers.
- Redirect priority, evaluated every cycle in either state: `exc_req` > `eret` > stall/normal.
  - `exc_req`: `pc`<=`EXC_ENTRY`.
  - `eret`: `pc`<=`epc`.
  - Both redirects clear `instr_valid` and `adel` and go to FETCH.
  - A redirect overrides `stall`.
  - A redirect in FETCH with `if_ready`=1 discards `if_rdata`.
- `exc_req` and `eret` together: `exc_req` wins; `epc` is ignored.
- PC arithmetic is 32-bit with no saturation. Targets are taken verbatim, including misaligned ones.

## Timing
- Reset values:
  - `pc`=`PC_RESET`, `instr`=0, `instr_valid`=0, `adel`=0.
  - `if_req`=0 while `reset` is high; 1 in the first cycle after release.
- Fetch latency: `instr_valid` rises on the edge after the cycle where `if_req`&`if_ready`.
- With zero-wait memory, throughput is one instruction per 2 cycles (FETCH→VALID→FETCH).
- A redirect takes effect on the next edge. The target's `if_req` is in the following cycle.
- `reset` asserted mid-fetch aborts immediately. No memory transaction completes during reset.
- `stall` is sampled only in VALID. In FETCH it has no effect.

## Configuration
- `PC_RANGE_CHECK_EN` defined:
  - In FETCH, if `pc[1:0]`!=0 or `pc` is outside [`TEXT_LO`,`TEXT_HI`]: no request is issued (`if_req`=0).
  - Next edge: `instr`<=32'h0 (nop), `adel`<=1, `instr_valid`<=1, go to VALID.
- `PC_RANGE_CHECK_EN` undefined:
  - `adel` is tied to 0.
  - All addresses are fetched unconditionally.

## Structure
- Shared package `pc_seq_pkg` holds:
  - the state enum (FETCH, VALID);
  - default constants `PC_RESET_DEF`, `EXC_ENTRY_DEF`, `TEXT_LO_DEF`, `TEXT_HI_DEF`;
  - the nop encoding.
- One sub-module, `pc_range_chk`, is natural: a combinational legality check (alignment plus range), instantiated only under `PC_RANGE_CHECK_EN`.

## Test plan
- Reset release, memory `if_ready`=1 always, `next_pc`=`pc`+4, no stall → `if_addr` sequence 0x3000, 0x3004, 0x3008 on alternate cycles; `instr` matches memory.
- `stall` held 3 cycles in VALID → `pc`/`instr` stable, `if_req`=0; after release `pc`=`next_pc`.
- `exc_req` in VALID with `stall`=1 → next cycle `pc`=0x4180, `instr_valid`=0, `if_req`=1.
- `exc_req` and `eret` same cycle with `epc`=0x3010 → `pc`=0x4180.
- FETCH with `if_ready`=1 and `eret`=1, `epc`=0x3020 → data discarded, `instr_valid` stays 0, next `if_addr`=0x3020.
- `PC_RANGE_CHECK_EN`: `eret` to 0x3002, then 0x7000 → no `if_req`; VALID with `instr`=0, `adel`=1 for each. Without the macro, the same stimulus gives `if_addr`=0x3002 and `adel`=0.
